vme_bus_master: RTL and testbench

VME_BUS_MASTER -- requirements
Module: vme_bus_master

---
 rtl/vme_pkg.sv | 34 +++
 rtl/vme_watchdog.sv | 34 +++
 rtl/vme_bus_master.sv | 189 ++++++++++++++++++
 tb/tb_vme_bus_master.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vme_pkg.sv
// +----------------------------------------------------------------------+
// | vme_pkg : shared state, lane and response-code definitions           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package vme_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DATA    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_RESP    = 3'd5
  } vme_state_e;

  localparam logic [1:0] C_LANE_NONE = 2'b00;
  localparam logic [1:0] C_LANE_D0   = 2'b01;
  localparam logic [1:0] C_LANE_D1   = 2'b10;
  localparam logic [1:0] C_LANE_BOTH = 2'b11;

  localparam logic [1:0] C_RSP_OK      = 2'd0;
  localparam logic [1:0] C_RSP_BERR    = 2'd1;
  localparam logic [1:0] C_RSP_TIMEOUT = 2'd2;

  // An empty lane mask means a full-width transfer.
  function automatic logic [1:0] eff_lanes(input logic [1:0] lanes);
    return (lanes == C_LANE_NONE) ? C_LANE_BOTH : lanes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vme_watchdog.sv
// +----------------------------------------------------------------------+
// | vme_watchdog : counts enabled cycles, expires on the TIMEOUT_CYC-th  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module vme_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam logic [15:0] C_LIMIT = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (clear)
      r_cnt <= '0;
    else if (enable && !expire)
      r_cnt <= r_cnt + 16'd1;
  end

  assign expire = enable && (r_cnt == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/vme_bus_master.sv
// +----------------------------------------------------------------------+
// | vme_bus_master : single-request VME bus master (arbitrate, strobe,   |
// | release, respond). Optional DATA watchdog: VME_MASTER_TIMEOUT_EN.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module vme_bus_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int SETUP_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_lanes,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              br_n,
  input  logic              bg_n,
  output logic              as_n,
  output logic              ds0_n,
  output logic              ds1_n,
  output logic              write_n,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dtack_n,
  input  logic              berr_n
);
  import vme_pkg::*;

  localparam logic [3:0] C_SETUP_LAST = 4'(SETUP_CYC - 1);

  vme_state_e        r_state;
  logic [1:0]        r_bg_meta, r_dtack_meta, r_berr_meta;
  logic              r_bg_s, r_dtack_s, r_berr_s;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_lanes;
  logic [3:0]        r_setup_cnt;
  logic [1:0]        r_code;
  logic              w_expire;
  logic              w_done;
  logic [1:0]        w_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bg_meta    <= 2'b11;
      r_dtack_meta <= 2'b11;
      r_berr_meta  <= 2'b11;
    end else begin
      r_bg_meta    <= {r_bg_meta[0], bg_n};
      r_dtack_meta <= {r_dtack_meta[0], dtack_n};
      r_berr_meta  <= {r_berr_meta[0], berr_n};
    end
  end

  assign r_bg_s    = r_bg_meta[1];
  assign r_dtack_s = r_dtack_meta[1];
  assign r_berr_s  = r_berr_meta[1];

`ifdef VME_MASTER_TIMEOUT_EN
  vme_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (r_state == ST_DATA),
    .clear  (r_state != ST_DATA),
    .expire (w_expire)
  );
`else
  assign w_expire    = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // Bus error outranks a simultaneous acknowledge.
  assign w_done = !r_berr_s || !r_dtack_s || w_expire;
  assign w_code = !r_berr_s  ? C_RSP_BERR :
                  !r_dtack_s ? C_RSP_OK   : C_RSP_TIMEOUT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
`ifdef VME_MASTER_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
      rsp_rdata   <= '0;
      br_n        <= 1'b1;
      as_n        <= 1'b1;
      ds0_n       <= 1'b1;
      ds1_n       <= 1'b1;
      write_n     <= 1'b1;
      addr_out    <= '0;
      data_out    <= '0;
      data_oe     <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_lanes     <= C_LANE_NONE;
      r_setup_cnt <= '0;
      r_code      <= C_RSP_OK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            r_write   <= req_write;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_lanes   <= req_lanes;
            req_ready <= 1'b0;
            br_n      <= 1'b0;
            r_state   <= ST_ARB;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_ARB: begin
          if (!r_bg_s) begin
            addr_out    <= r_addr;
            write_n     <= ~r_write;
            data_out    <= r_write ? r_wdata : '0;
            data_oe     <= r_write;
            r_setup_cnt <= '0;
            r_state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (r_setup_cnt == C_SETUP_LAST) begin
            as_n           <= 1'b0;
            {ds1_n, ds0_n} <= ~eff_lanes(r_lanes);
            r_state        <= ST_DATA;
          end else begin
            r_setup_cnt <= r_setup_cnt + 4'd1;
          end
        end
        ST_DATA: begin
          if (w_done) begin
            r_code    <= w_code;
            rsp_rdata <= (w_code == C_RSP_OK && !r_write) ? data_in : '0;
            as_n      <= 1'b1;
            ds0_n     <= 1'b1;
            ds1_n     <= 1'b1;
            br_n      <= 1'b1;
            data_oe   <= 1'b0;
            r_state   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (r_dtack_s && r_berr_s) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= (r_code != C_RSP_OK);
`ifdef VME_MASTER_TIMEOUT_EN
            rsp_timeout <= (r_code == C_RSP_TIMEOUT);
`endif
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid   <= 1'b0;
          rsp_err     <= 1'b0;
`ifdef VME_MASTER_TIMEOUT_EN
          rsp_timeout <= 1'b0;
`endif
          write_n     <= 1'b1;
          req_ready   <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vme_bus_master.sv
// +----------------------------------------------------------------------+
// | tb_vme_bus_master : directed self-checking bench for vme_bus_master  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_vme_bus_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_lanes = 2'b00;
  logic        req_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, addr_out, data_out;
  logic        br_n, as_n, ds0_n, ds1_n, write_n, data_oe;
  logic        bg_n = 1'b1, dtack_n = 1'b1, berr_n = 1'b1;
  logic [31:0] data_in = '0;

  int n_cmp = 0;
  int n_err = 0;

  vme_bus_master #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16), .SETUP_CYC(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_lanes(req_lanes),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .br_n(br_n), .bg_n(bg_n), .as_n(as_n), .ds0_n(ds0_n), .ds1_n(ds1_n),
    .write_n(write_n), .addr_out(addr_out), .data_out(data_out),
    .data_oe(data_oe), .data_in(data_in), .dtack_n(dtack_n), .berr_n(berr_n)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] ln);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_lanes = ln;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_as(input logic lvl, input string tag);
    int n = 0;
    while (as_n !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, as_n, lvl);
  endtask

  task automatic wait_rsp(input logic e_err, input logic e_to, input logic [31:0] e_rd,
                          input string tag);
    int  n = 0;
    logic rdy_seen = 1'b0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      if (req_ready !== 1'b0) rdy_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, rsp_valid, 1'b1);
    check({tag, "_ready_low"}, rdy_seen, 1'b0);
    check({tag, "_err"}, rsp_err, e_err);
    check({tag, "_timeout"}, rsp_timeout, e_to);
    check({tag, "_rdata"}, rsp_rdata, e_rd);
    @(negedge clk);
    check({tag, "_pulse"}, rsp_valid, 1'b0);
    check({tag, "_err_clr"}, rsp_err, 1'b0);
    check({tag, "_ready"}, req_ready, 1'b1);
  endtask

  initial begin
    int cnt;
    logic seen;

    // ---- reset values
    #12;
    check("rst_as_n", as_n, 1'b1);
    check("rst_br_n", br_n, 1'b1);
    check("rst_ds", {ds1_n, ds0_n}, 2'b11);
    check("rst_write_n", write_n, 1'b1);
    check("rst_oe_valid_ready", {data_oe, rsp_valid, rsp_err, rsp_timeout, req_ready}, 5'b0);
    check("rst_buses", {addr_out, data_out, rsp_rdata}, 96'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", req_ready, 1'b0);
    @(negedge clk);
    check("ready_after_edge", req_ready, 1'b1);

    // ---- write, grant delayed, dtack after 3 cycles
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b11);
    check("wr_ready_drop", req_ready, 1'b0);
    repeat (4) @(negedge clk);
    check("wr_br_n", br_n, 1'b0);
    check("wr_no_as_wo_grant", as_n, 1'b1);
    bg_n = 1'b0;
    wait_as(1'b0, "wr_as_low");
    check("wr_write_n", write_n, 1'b0);
    check("wr_addr", addr_out, 32'h10);
    check("wr_data", data_out, 32'hDEADBEEF);
    check("wr_oe", data_oe, 1'b1);
    check("wr_ds", {ds1_n, ds0_n}, 2'b00);
    repeat (3) @(negedge clk);
    check("wr_ds_held", {ds1_n, ds0_n, as_n}, 3'b000);
    dtack_n = 1'b0;
    wait_as(1'b1, "wr_release");
    check("wr_rel_ds", {ds1_n, ds0_n, br_n, data_oe}, 4'b1110);
    dtack_n = 1'b1;
    wait_rsp(1'b0, 1'b0, 32'h0, "wr");

    // ---- read, lane 0 only
    data_in = 32'h12345678;
    do_req(1'b0, 32'h20, 32'hFFFFFFFF, 2'b01);
    wait_as(1'b0, "rd_as_low");
    check("rd_ds", {ds1_n, ds0_n}, 2'b10);
    check("rd_write_n_oe", {write_n, data_oe}, 2'b10);
    check("rd_addr", addr_out, 32'h20);
    dtack_n = 1'b0;
    wait_as(1'b1, "rd_release");
    dtack_n = 1'b1;
    wait_rsp(1'b0, 1'b0, 32'h12345678, "rd");

    // ---- bus error alone, lane 1 only
    do_req(1'b0, 32'h30, 32'h0, 2'b10);
    wait_as(1'b0, "be_as_low");
    check("be_ds", {ds1_n, ds0_n}, 2'b01);
    berr_n = 1'b0;
    wait_as(1'b1, "be_release");
    berr_n = 1'b1;
    wait_rsp(1'b1, 1'b0, 32'h0, "berr");

    // ---- dtack and berr together
    do_req(1'b0, 32'h34, 32'h0, 2'b11);
    wait_as(1'b0, "bd_as_low");
    dtack_n = 1'b0; berr_n = 1'b0;
    wait_as(1'b1, "bd_release");
    dtack_n = 1'b1; berr_n = 1'b1;
    wait_rsp(1'b1, 1'b0, 32'h0, "both");

    // ---- empty lane mask strobes both lanes
    data_in = 32'hCAFEF00D;
    do_req(1'b0, 32'h38, 32'h0, 2'b00);
    wait_as(1'b0, "l0_as_low");
    check("l0_ds", {ds1_n, ds0_n}, 2'b00);
    dtack_n = 1'b0;
    wait_as(1'b1, "l0_release");
    dtack_n = 1'b1;
    wait_rsp(1'b0, 1'b0, 32'hCAFEF00D, "lane00");

    // ---- slow release: dtack held low after strobes drop
    data_in = 32'h0BADF00D;
    do_req(1'b0, 32'h3C, 32'h0, 2'b11);
    wait_as(1'b0, "sl_as_low");
    dtack_n = 1'b0;
    wait_as(1'b1, "sl_release");
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) seen = 1'b1;
    end
    check("sl_held_off", seen, 1'b0);
    dtack_n = 1'b1;
    wait_rsp(1'b0, 1'b0, 32'h0BADF00D, "slow");

    // ---- no slave response
    data_in = 32'h55AA55AA;
    do_req(1'b0, 32'h44, 32'h0, 2'b11);
    wait_as(1'b0, "to_as_low");
`ifdef VME_MASTER_TIMEOUT_EN
    cnt = 0;
    while (as_n === 1'b0 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("to_data_cycles", cnt, 16);
    wait_rsp(1'b1, 1'b1, 32'h0, "timeout");
`else
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (as_n !== 1'b0 || rsp_valid !== 1'b0) seen = 1'b1;
    end
    check("to_stays_data", seen, 1'b0);
    dtack_n = 1'b0;
    wait_as(1'b1, "to_release");
    dtack_n = 1'b1;
    wait_rsp(1'b0, 1'b0, 32'h55AA55AA, "late_ack");
`endif

    // ---- reset in the middle of a write
    do_req(1'b1, 32'h40, 32'hA5A5A5A5, 2'b11);
    wait_as(1'b0, "mr_as_low");
    check("mr_pre_data", data_out, 32'hA5A5A5A5);
    #2 rst_n = 1'b0;
    #1;
    check("mr_strobes", {as_n, ds1_n, ds0_n, br_n, write_n}, 5'b11111);
    check("mr_flags", {data_oe, rsp_valid, rsp_err, rsp_timeout, req_ready}, 5'b0);
    check("mr_buses", {addr_out, data_out, rsp_rdata}, 96'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("mr_ready_before_edge", req_ready, 1'b0);
    @(negedge clk);
    check("mr_ready_after_edge", req_ready, 1'b1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || as_n !== 1'b1) seen = 1'b1;
    end
    check("mr_no_rsp", seen, 1'b0);
    do_req(1'b1, 32'h50, 32'h13579BDF, 2'b11);
    wait_as(1'b0, "mr2_as_low");
    check("mr2_addr_data", {addr_out, data_out}, {32'h50, 32'h13579BDF});
    dtack_n = 1'b0;
    wait_as(1'b1, "mr2_release");
    dtack_n = 1'b1;
    wait_rsp(1'b0, 1'b0, 32'h0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
